// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state).
package program_loader_pkg;

  localparam int HEADER_WIDTH     = 16;
  localparam int BYTES_PER_WORD   = 4;
  localparam int WORD_WIDTH       = BYTES_PER_WORD * 8;
  localparam int BYTE_INDEX_WIDTH = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } loaderState_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects serial bytes into a little-endian instruction word.
// Byte 0 of a word ends up in bits [7:0] after four shifts.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byteEn,
  input  logic [7:0]            byteIn,
  output logic [WORD_WIDTH-1:0] nextWord,
  output logic                  wordComplete
);

  logic [WORD_WIDTH-1:0]       shiftReg;
  logic [BYTE_INDEX_WIDTH-1:0] byteIndex;

  // New bytes enter at the top so the first byte drifts down to the LSBs.
  assign nextWord     = {byteIn, shiftReg[WORD_WIDTH-1:8]};
  assign wordComplete = byteEn && (byteIndex == BYTE_INDEX_WIDTH'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg  <= '0;
      byteIndex <= '0;
    end else if (clear) begin
      shiftReg  <= '0;
      byteIndex <= '0;
    end else if (byteEn) begin
      shiftReg  <= nextWord;
      byteIndex <= byteIndex + BYTE_INDEX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into program memory while holding the CPU in reset.
// Build option: LOADER_CHECKSUM_EN enables the trailing checksum byte check.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  loaderState_t            state, nextState;
  logic [7:0]              lenLo;
  logic [HEADER_WIDTH-1:0] wordCount;
  logic [HEADER_WIDTH-1:0] wordIndex;
  logic [HEADER_WIDTH-1:0] headerCount;
  logic [WORD_WIDTH-1:0]   assembledWord;
  logic                    transfer;
  logic                    dataTransfer;
  logic                    wordComplete;
  logic                    startAccept;
  logic                    headerBad;
  logic                    lastWord;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              checksum;
`endif

  assign transfer     = byte_valid && byte_ready;
  assign dataTransfer = transfer && (state == DATA);
  assign startAccept  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign headerCount  = {byte_in, lenLo};
  assign headerBad    = (headerCount == '0) || ({16'd0, headerCount} > 32'(MEMORY_DEPTH));
  assign lastWord     = ({1'b0, wordIndex} + 17'd1) >= {1'b0, wordCount};

  loader_word_assembler assembler (
    .clk          (clk),
    .reset        (reset),
    .clear        (startAccept),
    .byteEn       (dataTransfer),
    .byteIn       (byte_in),
    .nextWord     (assembledWord),
    .wordComplete (wordComplete)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Status outputs are pure functions of state so reset clears them without waiting for a clock.
  always_comb begin
    nextState  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (state)
      IDLE: if (start) nextState = LEN_LO;
      LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) nextState = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) nextState = headerBad ? ERROR : DATA;
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (wordComplete) nextState = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        nextState = lastWord ? CHECK : DATA;
`else
        nextState = lastWord ? DONE : DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) nextState = (byte_in == checksum) ? DONE : ERROR;
      end
`endif
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) nextState = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) nextState = LEN_LO;
      end
      default: nextState = IDLE;
    endcase
  end

  // Memory address/data are captured as WRITE is entered and held until the next word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lenLo     <= '0;
      wordCount <= '0;
      wordIndex <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (state)
        LEN_LO: if (transfer) lenLo <= byte_in;
        LEN_HI: if (transfer) wordCount <= headerCount;
        DATA: begin
          if (dataTransfer) begin
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ byte_in;
`endif
            if (wordComplete) begin
              mem_addr  <= {14'd0, wordIndex, 2'b00};
              mem_wdata <= assembledWord;
            end
          end
        end
        WRITE: wordIndex <= wordIndex + 16'd1;
        default: begin
          if (startAccept) begin
            wordIndex <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default and LOADER_CHECKSUM_EN builds).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];

  program_loader #(.MEMORY_DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Records every memory write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one byte from a negedge and returns at the negedge after it was accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) checkOutput("byteReadyTimeout", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},     {31'd0, busy},       32'd0);
    checkOutput({tag, "_ready"},    {31'd0, byte_ready}, 32'd0);
    checkOutput({tag, "_we"},       {31'd0, mem_we},     32'd0);
    checkOutput({tag, "_done"},     {31'd0, done},       32'd0);
    checkOutput({tag, "_error"},    {31'd0, error},      32'd0);
    checkOutput({tag, "_cpuReset"}, {31'd0, cpu_reset},  32'd1);
    checkOutput({tag, "_addr"},     mem_addr,            32'd0);
    checkOutput({tag, "_wdata"},    mem_wdata,           32'd0);
  endtask

  // Reference two-word program; optional idle gap between data bytes and a start poke mid-load.
  task automatic runReferenceLoad(input string tag, input bit gap, input bit pokeStart);
    logic [7:0] dataBytes[8] = '{8'h13, 8'h00, 8'h08, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pulseStart();
    checkOutput({tag, "_busyAfterStart"}, {31'd0, busy},      32'd1);
    checkOutput({tag, "_cpuResetHigh"},   {31'd0, cpu_reset}, 32'd1);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    for (int i = 0; i < 8; i++) begin
      if (gap && i != 0) begin
        start = (pokeStart && i == 5);
        @(negedge clk);
        start = 1'b0;
      end
      applyStimulus(dataBytes[i]);
      if (i == 3) begin
        checkOutput({tag, "_we0"},    {31'd0, mem_we}, 32'd1);
        checkOutput({tag, "_addr0"},  mem_addr,        32'h0);
        checkOutput({tag, "_wdata0"}, mem_wdata,       32'h20080013);
      end
    end
    checkOutput({tag, "_we1"},    {31'd0, mem_we}, 32'd1);
    checkOutput({tag, "_addr1"},  mem_addr,        32'h4);
    checkOutput({tag, "_wdata1"}, mem_wdata,       32'hDDCCBBAA);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'h3B);
`else
    @(negedge clk);
`endif
    checkOutput({tag, "_done"},     {31'd0, done},       32'd1);
    checkOutput({tag, "_cpuReset"}, {31'd0, cpu_reset},  32'd0);
    checkOutput({tag, "_busyDone"}, {31'd0, busy},       32'd0);
    checkOutput({tag, "_readyDone"},{31'd0, byte_ready}, 32'd0);
    checkOutput({tag, "_writes"},   wrAddr.size(),       32'd2);
    if (wrAddr.size() == 2) begin
      checkOutput({tag, "_logAddr0"}, wrAddr[0], 32'h0);
      checkOutput({tag, "_logData0"}, wrData[0], 32'h20080013);
      checkOutput({tag, "_logAddr1"}, wrAddr[1], 32'h4);
      checkOutput({tag, "_logData1"}, wrData[1], 32'hDDCCBBAA);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("idleAfterReset");

    runReferenceLoad("basic", 1'b0, 1'b0);

    // Bytes offered in DONE must be ignored.
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("doneHolds",     {31'd0, done}, 32'd1);
    checkOutput("doneNoWrites",  wrAddr.size(), 32'd2);

    // Zero-length header is rejected.
    pulseStart();
    checkOutput("restartCpuReset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("restartDone",     {31'd0, done},      32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("zeroLenError",    {31'd0, error},     32'd1);
    checkOutput("zeroLenCpuReset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("zeroLenBusy",     {31'd0, busy},      32'd0);

    // One word over capacity is rejected.
    pulseStart();
    checkOutput("restartError", {31'd0, error}, 32'd0);
    applyStimulus(8'h21);
    applyStimulus(8'h00);
    checkOutput("overLenError",    {31'd0, error},     32'd1);
    checkOutput("overLenCpuReset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("overLenNoWrites", wrAddr.size(),      32'd0);

    runReferenceLoad("gapped", 1'b1, 1'b1);

    // Exactly MEMORY_DEPTH words is accepted, then reset aborts mid-word.
    pulseStart();
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    checkOutput("fullLenReady", {31'd0, byte_ready}, 32'd1);
    checkOutput("fullLenError", {31'd0, error},      32'd0);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    reset = 1'b1;
    #1;
    checkIdleOutputs("midLoadReset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("noSelfStart");
    runReferenceLoad("reload", 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    checkOutput("ckWdata", mem_wdata, 32'h04030201);
    applyStimulus(8'h04);
    checkOutput("ckGoodDone", {31'd0, done}, 32'd1);

    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    applyStimulus(8'h05);
    checkOutput("ckBadError",    {31'd0, error},     32'd1);
    checkOutput("ckBadCpuReset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("ckBadWrites",   wrAddr.size(),      32'd1);
    if (wrAddr.size() == 1) begin
      checkOutput("ckBadAddr", wrAddr[0], 32'h0);
      checkOutput("ckBadData", wrData[0], 32'h04030201);
    end
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, meaning program memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a load, sampled in IDLE, DONE or ERROR.
REQ-005 SHALL have port byte_in  input  8  serial program byte.
REQ-006 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 SHALL have port mem_we  output  1  one-cycle write strobe to program memory.
REQ-009 SHALL have port mem_addr  output  32  byte address of the word being written (word aligned).
REQ-010 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-011 SHALL have port cpu_reset  output  1  holds the processor in reset while high.
REQ-012 SHALL have ports busy, done, error  output  1 each  load in progress / load complete / load aborted.

Function
REQ-013 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
REQ-014 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in LEN_LO, LEN_HI and DATA.
REQ-015 IDLE, DONE or ERROR with start=1 SHALL enter LEN_LO next cycle, clearing done, error, the word index and the byte index.
REQ-016 Header SHALL be a 16-bit word count N, low byte first (LEN_LO->LEN_HI->DATA on each transfer).
REQ-017 On the LEN_HI transfer, N=0 or N>MEMORY_DEPTH SHALL go to ERROR instead of DATA.
REQ-018 DATA bytes SHALL assemble little-endian: byte k of a word into bits [8k+7:8k].
REQ-019 On the 4th byte of a word SHALL enter WRITE; in WRITE mem_we=1 for exactly one cycle with mem_addr=word_index*4 and mem_wdata = assembled word.
REQ-020 After WRITE: word_index+1<N SHALL return to DATA; otherwise SHALL enter DONE (or the checksum step, REQ-027).
REQ-021 mem_we SHALL be 0 in every state other than WRITE; mem_addr/mem_wdata SHALL hold their last values otherwise.
REQ-022 busy SHALL be 1 in LEN_LO, LEN_HI, DATA, WRITE; done SHALL be 1 only in DONE; error only in ERROR.
REQ-023 cpu_reset SHALL be 1 in every state except DONE; it falls the cycle DONE is entered and rises the cycle start is accepted from DONE.
REQ-024 byte_valid with byte_ready=0 SHALL be ignored (no implicit buffering); start while busy SHALL be ignored.

Reset
REQ-025 Asserting reset at any time, including mid-load, SHALL immediately force IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_reset=1, and clear all indices.
REQ-026 Deassertion SHALL not by itself start a load; a partially written memory is not restored.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined: after the last WRITE SHALL enter CHECK, accept one byte (byte_ready=1), and go to DONE if it equals XOR of all data bytes, else ERROR; without it: no CHECK state, last WRITE goes directly to DONE and no extra byte is consumed.

Structure
REQ-028 Shared package program_loader_pkg SHALL hold the state enum, header width (16) and bytes-per-word (4) constants.
REQ-029 Sub-module loader_word_assembler SHALL hold the byte shift register and byte index, reporting word_complete; FSM, counters and checksum stay in program_loader.

Verification
REQ-030 N=2, bytes 02 00 13 00 08 20 AA BB CC DD -> writes 0x20080013 @0x0 and 0xDDCCBBAA @0x4, done=1, cpu_reset falls.
REQ-031 Header 00 00, then 21 00 with MEMORY_DEPTH=32 -> error=1, no mem_we, cpu_reset stays 1.
REQ-032 byte_valid toggling 1/0 each cycle during DATA -> same words/addresses as REQ-030; mem_we pulses once per word.
REQ-033 reset asserted after 3 data bytes -> same-cycle IDLE, all outputs at reset values; new start reloads cleanly.
REQ-034 LOADER_CHECKSUM_EN, N=1 word 01 02 03 04, checksum 04 -> DONE; checksum 05 -> ERROR with word already written @0x0.
